// File: rtl/pipe_tag_tracker.sv
`default_nettype none
// ============================================================================
// Module   : pipe_tag_tracker
// Purpose  : Per-stage transaction tag tracker for an N-stage pipeline.
//            Stage 0 (IF) takes a fresh tag on every issue. Tags then shift
//            one stage per adv strobe. It also keeps per-stage valid bits,
//            per-stage flush, an optional bubble-on-drain mode, an occupancy
//            count and retire accounting at the last stage (WB).
//            Observation only: it has no effect on core function.
// Ports    : clk        clock
//            rstn       asynchronous active-low reset
//            issue      stage 0 accepts a new transaction
//            adv        adv[k-1] loads stage k from stage k-1
//            flush      flush[i] invalidates the current occupant of stage i
//            next_tag   tag the next issue will receive
//            stage_tag  packed tags, stage i at [i*TAG_W +: TAG_W]
//            stage_vld  per-stage valid
//            occupancy  popcount of stage_vld (combinational)
//            retire     registered pulse: valid tag entered the last stage
//            retire_cnt number of retire pulses, wrapping
// Revision : 1.0 - initial release
// ============================================================================
module pipe_tag_tracker #(
    parameter int STAGES       = 5,
    parameter int TAG_W        = 6,
    parameter int CNT_W        = 16,
    parameter int CLR_ON_DRAIN = 0
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       issue,
    input  logic [STAGES-2:0]          adv,
    input  logic [STAGES-1:0]          flush,
    output logic [TAG_W-1:0]           next_tag,
    output logic [STAGES*TAG_W-1:0]    stage_tag,
    output logic [STAGES-1:0]          stage_vld,
    output logic [$clog2(STAGES+1)-1:0] occupancy,
    output logic                       retire,
    output logic [CNT_W-1:0]           retire_cnt
);

    localparam int c_OCC_W = $clog2(STAGES + 1);
    localparam bit c_CLR   = (CLR_ON_DRAIN != 0);

    logic [TAG_W-1:0]   r_tag [STAGES];
    logic [STAGES-1:0]  r_vld;
    logic [TAG_W-1:0]   r_next_tag;
    logic               r_retire;
    logic [CNT_W-1:0]   r_retire_cnt;

    logic [TAG_W-1:0]   w_tag_nxt [STAGES];
    logic [STAGES-1:0]  w_vld_nxt;
    logic [STAGES-1:0]  w_drain;
    logic               w_retire;
    logic [c_OCC_W-1:0] w_occ;

    // The last stage has no outgoing advance, so it is never drained.
    assign w_drain = {1'b0, adv};

    // A valid, unflushed occupant of the second-to-last stage moving forward
    // is a retirement. A bubble or a flushed tag never counts.
    assign w_retire = adv[STAGES-2] & r_vld[STAGES-2] & ~flush[STAGES-2];

    // Next-state for every stage is computed from pre-edge values, so a full
    // shift moves each tag exactly one stage. Load has priority over flush
    // and drain: flush acts on the current occupant, not on the incoming one.
    always_comb begin
        w_tag_nxt = r_tag;
        w_vld_nxt = r_vld;

        if (issue) begin
            w_tag_nxt[0] = r_next_tag;
            w_vld_nxt[0] = 1'b1;
        end else if (flush[0] || (c_CLR && w_drain[0])) begin
            w_vld_nxt[0] = 1'b0;
        end

        for (int i = 1; i < STAGES; i++) begin
            if (adv[i-1]) begin
                // The tag value is copied even when the source is a bubble.
                w_tag_nxt[i] = r_tag[i-1];
                w_vld_nxt[i] = r_vld[i-1] & ~flush[i-1];
            end else if (flush[i] || (c_CLR && w_drain[i])) begin
                w_vld_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < STAGES; i++) begin
                r_tag[i] <= '0;
            end
            r_vld        <= '0;
            r_next_tag   <= '0;
            r_retire     <= 1'b0;
            r_retire_cnt <= '0;
        end else begin
            r_tag    <= w_tag_nxt;
            r_vld    <= w_vld_nxt;
            r_retire <= w_retire;
            if (issue) begin
                r_next_tag <= r_next_tag + TAG_W'(1);
            end
            if (w_retire) begin
                r_retire_cnt <= r_retire_cnt + CNT_W'(1);
            end
        end
    end

    // Popcount of the valid vector.
    always_comb begin
        w_occ = '0;
        for (int i = 0; i < STAGES; i++) begin
            w_occ = w_occ + c_OCC_W'(r_vld[i]);
        end
    end

    generate
        for (genvar g = 0; g < STAGES; g++) begin : g_pack
            assign stage_tag[g*TAG_W +: TAG_W] = r_tag[g];
        end
    endgenerate

    assign next_tag   = r_next_tag;
    assign stage_vld  = r_vld;
    assign occupancy  = w_occ;
    assign retire     = r_retire;
    assign retire_cnt = r_retire_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_tag_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_tag_tracker
// Purpose  : Directed self-checking bench for pipe_tag_tracker. Three
//            instances share one stimulus stream: the default configuration,
//            a 3-bit tag variant and a bubble-on-drain variant.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_tag_tracker;

    logic       clk;
    logic       rstn;
    logic       issue;
    logic [3:0] adv;
    logic [4:0] flush;

    // Default configuration: STAGES=5, TAG_W=6, CLR_ON_DRAIN=0
    logic [5:0]  a_next_tag;
    logic [29:0] a_stage_tag;
    logic [4:0]  a_stage_vld;
    logic [2:0]  a_occupancy;
    logic        a_retire;
    logic [15:0] a_retire_cnt;

    // TAG_W=3
    logic [2:0]  b_next_tag;
    logic [14:0] b_stage_tag;
    logic [4:0]  b_stage_vld;
    logic [2:0]  b_occupancy;
    logic        b_retire;
    logic [15:0] b_retire_cnt;

    // CLR_ON_DRAIN=1
    logic [5:0]  c_next_tag;
    logic [29:0] c_stage_tag;
    logic [4:0]  c_stage_vld;
    logic [2:0]  c_occupancy;
    logic        c_retire;
    logic [15:0] c_retire_cnt;

    int n_vec;
    int n_err;

    pipe_tag_tracker #(.STAGES(5), .TAG_W(6), .CNT_W(16), .CLR_ON_DRAIN(0)) u_dut (
        .clk(clk), .rstn(rstn), .issue(issue), .adv(adv), .flush(flush),
        .next_tag(a_next_tag), .stage_tag(a_stage_tag), .stage_vld(a_stage_vld),
        .occupancy(a_occupancy), .retire(a_retire), .retire_cnt(a_retire_cnt)
    );

    pipe_tag_tracker #(.STAGES(5), .TAG_W(3), .CNT_W(16), .CLR_ON_DRAIN(0)) u_dut_w3 (
        .clk(clk), .rstn(rstn), .issue(issue), .adv(adv), .flush(flush),
        .next_tag(b_next_tag), .stage_tag(b_stage_tag), .stage_vld(b_stage_vld),
        .occupancy(b_occupancy), .retire(b_retire), .retire_cnt(b_retire_cnt)
    );

    pipe_tag_tracker #(.STAGES(5), .TAG_W(6), .CNT_W(16), .CLR_ON_DRAIN(1)) u_dut_clr (
        .clk(clk), .rstn(rstn), .issue(issue), .adv(adv), .flush(flush),
        .next_tag(c_next_tag), .stage_tag(c_stage_tag), .stage_vld(c_stage_vld),
        .occupancy(c_occupancy), .retire(c_retire), .retire_cnt(c_retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus, then sample 1 ns after the edge.
    task automatic cyc(input logic i_iss, input logic [3:0] i_adv, input logic [4:0] i_flush);
        issue = i_iss;
        adv   = i_adv;
        flush = i_flush;
        @(posedge clk);
        #1;
        issue = 1'b0;
        adv   = '0;
        flush = '0;
    endtask

    task automatic do_reset();
        issue = 1'b0;
        adv   = '0;
        flush = '0;
        rstn  = 1'b0;
        @(posedge clk);
        #1;
        rstn  = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        issue = 1'b0;
        adv   = '0;
        flush = '0;
        rstn  = 1'b0;
        #2;

        // ---- Reset state
        check("rst_next_tag", 32'(a_next_tag), 32'd0);
        check("rst_stage_vld", 32'(a_stage_vld), 32'd0);
        check("rst_occupancy", 32'(a_occupancy), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // ---- Three issues, no advance
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'b0000, 5'b00000);
        check("iss3_next_tag", 32'(a_next_tag), 32'd3);
        check("iss3_tag0", 32'(a_stage_tag[5:0]), 32'd2);
        check("iss3_vld", 32'(a_stage_vld), 32'b00001);
        check("iss3_occ", 32'(a_occupancy), 32'd1);

        // ---- Asynchronous reset mid-run, sampled with no clock edge
        #2;
        rstn = 1'b0;
        #1;
        check("arst_next_tag", 32'(a_next_tag), 32'd0);
        check("arst_stage_tag", 32'(a_stage_tag), 32'd0);
        check("arst_vld", 32'(a_stage_vld), 32'd0);
        check("arst_occ", 32'(a_occupancy), 32'd0);
        check("arst_retire", 32'(a_retire), 32'd0);
        check("arst_cnt", 32'(a_retire_cnt), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // ---- Full shift with issue every cycle for six cycles
        for (int i = 0; i < 4; i++) cyc(1'b1, 4'b1111, 5'b00000);
        check("shift_c4_retire", 32'(a_retire), 32'd0);
        cyc(1'b1, 4'b1111, 5'b00000);
        check("shift_c5_retire", 32'(a_retire), 32'd1);
        check("shift_c5_cnt", 32'(a_retire_cnt), 32'd1);
        cyc(1'b1, 4'b1111, 5'b00000);
        check("shift_c6_retire", 32'(a_retire), 32'd1);
        check("shift_c6_cnt", 32'(a_retire_cnt), 32'd2);
        check("shift_tags", 32'(a_stage_tag), {2'b00, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5});
        check("shift_vld", 32'(a_stage_vld), 32'b11111);
        check("shift_occ", 32'(a_occupancy), 32'd5);
        cyc(1'b0, 4'b0000, 5'b00000);
        check("shift_idle_retire", 32'(a_retire), 32'd0);
        check("shift_idle_cnt", 32'(a_retire_cnt), 32'd2);

        // ---- Flush at the source of an advance produces a bubble
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 4'b0000, 5'b00000);
        cyc(1'b0, 4'b0001, 5'b00000);
        cyc(1'b0, 4'b0010, 5'b00000);
        check("fl_pre_tag2", 32'(a_stage_tag[17:12]), 32'd4);
        cyc(1'b0, 4'b0100, 5'b00100);
        check("fl_tag3", 32'(a_stage_tag[23:18]), 32'd4);
        check("fl_vld", 32'(a_stage_vld), 32'b00011);
        check("fl_occ", 32'(a_occupancy), 32'd2);
        cyc(1'b0, 4'b1000, 5'b00000);
        check("fl_tag4", 32'(a_stage_tag[29:24]), 32'd4);
        check("fl_vld4", 32'(a_stage_vld[4]), 32'd0);
        check("fl_retire", 32'(a_retire), 32'd0);
        check("fl_cnt", 32'(a_retire_cnt), 32'd0);

        // ---- Drain without refill: hold vs bubble
        do_reset();
        cyc(1'b1, 4'b0000, 5'b00000);
        cyc(1'b1, 4'b0000, 5'b00000);
        cyc(1'b1, 4'b0001, 5'b00000);
        check("dr_clr_pre_vld", 32'(c_stage_vld), 32'b00011);
        cyc(1'b0, 4'b0010, 5'b00000);
        check("dr_hold_vld", 32'(a_stage_vld), 32'b00111);
        check("dr_hold_occ", 32'(a_occupancy), 32'd3);
        check("dr_hold_tag1", 32'(a_stage_tag[11:6]), 32'd1);
        check("dr_hold_tag2", 32'(a_stage_tag[17:12]), 32'd1);
        check("dr_clr_vld", 32'(c_stage_vld), 32'b00101);
        check("dr_clr_occ", 32'(c_occupancy), 32'd2);
        check("dr_clr_tag1", 32'(c_stage_tag[11:6]), 32'd1);

        // ---- 3-bit tag wrap
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1'b1, 4'b0000, 5'b00000);
        check("w3_8_next", 32'(b_next_tag), 32'd0);
        check("w3_8_tag0", 32'(b_stage_tag[2:0]), 32'd7);
        cyc(1'b1, 4'b0000, 5'b00000);
        check("w3_9_next", 32'(b_next_tag), 32'd1);
        check("w3_9_tag0", 32'(b_stage_tag[2:0]), 32'd0);
        check("w6_9_next", 32'(a_next_tag), 32'd9);

        // ---- Flush everything together with an issue
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'b1111, 5'b00000);
        check("fa_pre_cnt", 32'(a_retire_cnt), 32'd0);
        cyc(1'b1, 4'b1111, 5'b00000);
        check("fa_pre_retire", 32'(a_retire), 32'd1);
        check("fa_pre_cnt1", 32'(a_retire_cnt), 32'd1);
        check("fa_pre_vld", 32'(a_stage_vld), 32'b11111);
        cyc(1'b1, 4'b0000, 5'b11111);
        check("fa_vld", 32'(a_stage_vld), 32'b00001);
        check("fa_tag0", 32'(a_stage_tag[5:0]), 32'd13);
        check("fa_next", 32'(a_next_tag), 32'd14);
        check("fa_occ", 32'(a_occupancy), 32'd1);
        check("fa_retire", 32'(a_retire), 32'd0);
        check("fa_cnt", 32'(a_retire_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
